vga_fb_scheduler: RTL
=====================

Name: vga_fb_scheduler

Overview:
- Sits between the VGA scan-out path and the single-port framebuffer RAM that holds 24-bit pixels.
- Prefetches pixels, in raster order, into a small FIFO that feeds the VGA controller.
- Grants spare RAM cycles to a CPU write port.
- Produces the same address mapping as the display memory: line-linear, with odd lines optionally reversed (serpentine).

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, framebuffer word-address width.
- DATA_W, 24, pixel width (RGB888).
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2, >=4).
- SERPENTINE, 1, 1 = odd lines stored reversed (addr = v*H_ACTIVE + H_ACTIVE-1-h).

Ports:
- clk in 1: single clock.
- reset in 1: synchronous, active-high.
- frame_start in 1: one-cycle pulse that restarts the scan at (h=0, v=0).
- pix_pop in 1: display consumes the FIFO head.
- pix_data out DATA_W: FIFO head pixel.
- pix_empty out 1: FIFO empty.
- underflow out 1: sticky; a pop occurred while empty.
- cpu_wr_valid in 1: CPU write request.
- cpu_wr_addr in ADDR_W: CPU write address.
- cpu_wr_data in DATA_W: CPU write data.
- cpu_wr_ready out 1: CPU write accepted this cycle.
- mem_en out 1: RAM access strobe.
- mem_we out 1: 1 = write, 0 = read.
- mem_addr out ADDR_W: RAM address.
- mem_wdata out DATA_W: RAM write data.
- mem_rdata in DATA_W: RAM read data, valid exactly 1 cycle after a read.

Behaviour:
- Reset (synchronous, active-high):
  - Scan position h=0, v=0; done=0.
  - FIFO count=0 and storage cleared, so pix_data=0 and pix_empty=1.
  - No read in flight; underflow=0.
  - While reset is high: mem_en=0, mem_we=0, cpu_wr_ready=0, mem_addr=0, mem_wdata=0.
- Occupancy occ = FIFO count + inflight (inflight = 1 if a read was issued last cycle).
- fetch_ok = !done && !frame_start && occ < FIFO_DEPTH.
- urgent = fetch_ok && occ < FIFO_DEPTH/2.
- Grant, evaluated combinationally each cycle in priority order:
  - urgent -> READ.
  - else cpu_wr_valid -> WRITE.
  - else fetch_ok -> READ.
  - else IDLE.
- READ cycle:
  - mem_en=1, mem_we=0.
  - mem_addr = v*H_ACTIVE + h_eff, where h_eff = (SERPENTINE && v[0]) ? H_ACTIVE-1-h : h.
  - Compute the address with shift/add, ADDR_W-bit result.
  - Then advance h; at h=H_ACTIVE-1, h wraps to 0 and v increments.
  - At the last pixel (v=V_ACTIVE-1, h=H_ACTIVE-1), set done=1; no further fetches until frame_start.
- WRITE cycle:
  - mem_en=1, mem_we=1, mem_addr=cpu_wr_addr, mem_wdata=cpu_wr_data, cpu_wr_ready=1.
  - cpu_wr_ready is never 1 without cpu_wr_valid.
  - CPU must hold valid, addr and data stable until ready.
- IDLE cycle: mem_en=0, cpu_wr_ready=0.
- Read return: on the cycle after a READ, mem_rdata is pushed into the FIFO tail.
  - It is discarded if frame_start or reset was asserted in the READ's following cycle, i.e. a kill on the cycle the data returns.
  - occ < FIFO_DEPTH guarantees the FIFO never overflows.
- Pop:
  - pix_pop && !pix_empty removes the head; pix_data updates next cycle (head shown combinationally from storage).
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty: ignored and underflow<=1.
- frame_start, in its own cycle:
  - FIFO flushed (count=0).
  - h=v=0, done=0, underflow=0.
  - Any returning read data is discarded.
  - No READ is granted; a CPU WRITE may be granted.
  - The first prefetch read (addr 0) is issued the next cycle.
- Latency: from frame_start, pix_empty deasserts 3 cycles later (read in cycle +1, data in cycle +2, visible cycle +3).
- Throughput: at one pop per 2 cycles, the CPU gets at least ~50% of cycles once the FIFO is above half full.

Test Plan:
- Reset, then frame_start with no pops and no CPU traffic:
  - Reads to addresses 0..7 on consecutive cycles, then mem_en=0.
  - pix_empty=0 at frame_start+3; FIFO holds 8 entries.
- Serpentine check: set V_ACTIVE=2, H_ACTIVE=640, pop every cycle.
  - Read addresses 0..639, then 1279 down to 640.
  - Then done=1 and no further reads.
- CPU priority with full FIFO: cpu_wr_valid=1, addr=0x12345, data=0xABCDEF.
  - cpu_wr_ready=1 the same cycle, with mem_we=1 and mem_addr=0x12345.
- Urgent preemption: occ=3 (<4) while cpu_wr_valid=1.
  - READ is granted and cpu_wr_ready=0.
  - The write completes once occ reaches 4.
- Underflow: pop with pix_empty=1.
  - FIFO unchanged; underflow=1 stays high until the next frame_start, then clears.
- frame_start while a read is in flight (occ=5):
  - Returned data dropped; count=0.
  - The next read is to address 0, issued one cycle after frame_start.

Source files
------------

// File: rtl/vga_fb_scheduler.sv
// Framebuffer arbiter: raster-order prefetch into a small pixel FIFO for scan-out,
// with spare single-port RAM cycles handed to a CPU write port.
module vga_fb_scheduler #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int SERPENTINE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underflow,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int H_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int V_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int P_W = $clog2(FIFO_DEPTH);
  localparam int C_W = P_W + 1;
  localparam logic [H_W-1:0]    H_LAST  = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0]    V_LAST  = V_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LINE_SZ = ADDR_W'(H_ACTIVE);
  localparam logic [C_W-1:0]    DEPTH_C = C_W'(FIFO_DEPTH);
  localparam logic [C_W-1:0]    HALF_C  = C_W'(FIFO_DEPTH / 2);

  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [P_W-1:0]    wptr_q, rptr_q;
  logic [C_W-1:0]    cnt_q;
  logic              infl_q;
  logic              uf_q;

  logic [C_W-1:0]    occ;
  logic              fetch_ok, urgent, gnt_rd, gnt_wr;
  logic [H_W-1:0]    h_eff;
  logic [ADDR_W-1:0] rd_addr;
  logic              push, pop_ok;

  // The line base is accumulated rather than multiplied, so the address is one adder.
  assign occ     = cnt_q + {{(C_W-1){1'b0}}, infl_q};
  assign h_eff   = ((SERPENTINE != 0) && v_q[0]) ? (H_LAST - h_q) : h_q;
  assign rd_addr = base_q + ADDR_W'(h_eff);

  always_comb begin
    fetch_ok = !done_q && !frame_start && (occ < DEPTH_C);
    urgent   = fetch_ok && (occ < HALF_C);
    gnt_rd   = 1'b0;
    gnt_wr   = 1'b0;
    if (!reset) begin
      if (urgent)            gnt_rd = 1'b1;
      else if (cpu_wr_valid) gnt_wr = 1'b1;
      else if (fetch_ok)     gnt_rd = 1'b1;
    end
  end

  assign mem_en       = gnt_rd | gnt_wr;
  assign mem_we       = gnt_wr;
  assign cpu_wr_ready = gnt_wr;
  assign mem_addr     = gnt_wr ? cpu_wr_addr : (gnt_rd ? rd_addr : '0);
  assign mem_wdata    = gnt_wr ? cpu_wr_data : '0;

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    base_d = base_q;
    done_d = done_q;
    if (frame_start) begin
      h_d    = '0;
      v_d    = '0;
      base_d = '0;
      done_d = 1'b0;
    end else if (gnt_rd) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        v_d    = v_q + 1'b1;
        base_d = base_q + LINE_SZ;
        if (v_q == V_LAST) done_d = 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Returning read data is dropped when frame_start lands on its return cycle.
  assign push   = infl_q && !frame_start;
  assign pop_ok = pix_pop && (cnt_q != '0) && !frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      base_q <= '0;
      done_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      infl_q <= 1'b0;
      uf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      done_q <= done_d;
      infl_q <= gnt_rd;
      if (frame_start) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        uf_q   <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wptr_q] <= mem_rdata;
          wptr_q         <= wptr_q + 1'b1;
        end
        if (pop_ok) rptr_q <= rptr_q + 1'b1;
        case ({push, pop_ok})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
        if (pix_pop && (cnt_q == '0)) uf_q <= 1'b1;
      end
    end
  end

  assign pix_data  = fifo_q[rptr_q];
  assign pix_empty = (cnt_q == '0);
  assign underflow = uf_q;

endmodule
